regfile_rename_mp: RTL and testbench
====================================

// Module: regfile_rename_mp
// PURPOSE
//  Architectural register file plus per-register rename table (ROB tag + busy bit) for the out-of-order core.
//  Generalises the single-port design to NUM_RD query ports and NUM_CMT in-order commit ports.
//  Sits between dispatcher (rename + operand query), ROB (commit) and CDB (rollback/flush).
//  Busy is an explicit bit; no sentinel tag value is used.
// PARAMETERS
//  XLEN      32  data width
//  NREG      32  architectural registers; x0 hardwired to zero, never busy
//  RIDX_W    5   register index width, clog2(NREG)
//  TAG_W     4   ROB tag width
//  NUM_RD    2   operand query ports (2 per dispatched instruction)
//  NUM_CMT   1   commit ports; index order = program order, higher index is younger
// PORTS
//  clk_in     in   1              clock
//  rst_in     in   1              synchronous active-high reset
//  rdy_in     in   1              global enable; low freezes all state
//  dsp_en     in   1              dispatcher renames dsp_rd to dsp_tag this cycle
//  dsp_rd     in   RIDX_W         destination register of dispatched instruction
//  dsp_tag    in   TAG_W          ROB tag allocated to it
//  q_rs       in   NUM_RD*RIDX_W  query register indices, port i at [i*RIDX_W +: RIDX_W]
//  q_val      out  NUM_RD*XLEN    operand value per port
//  q_busy     out  NUM_RD         1 = operand pending, wait for q_tag
//  q_tag      out  NUM_RD*TAG_W   producing ROB tag, valid when q_busy=1, else 0
//  cmt_en     in   NUM_CMT        commit valid per port
//  cmt_rd     in   NUM_CMT*RIDX_W commit destination register
//  cmt_tag    in   NUM_CMT*TAG_W  ROB tag being retired
//  cmt_val    in   NUM_CMT*XLEN   committed result
//  flush      in   1              mispredict rollback from CDB
// BEHAVIOUR
//  - Reset (rst_in=1 at posedge, overrides rdy_in): all values 0, all busy 0, all tags 0.
//  - Outputs are combinational (zero latency) from state + same-cycle commit inputs; q_* driven even when rdy_in=0.
//  - Query sees state AFTER this cycle's commits, BEFORE this cycle's dispatch (dispatcher never sees own rename):
//    q_rs=0 -> val 0, busy 0, tag 0.
//    else if some cmt_en[k] with cmt_rd[k]==q_rs: val = youngest such cmt_val; busy cleared if that commit's tag == table tag.
//    else val/busy/tag from table. If flush=1: busy 0, tag 0 for all ports (values still forwarded).
//  - Posedge update (rdy_in=1), in order:
//    1. Commits: for each k with cmt_en[k], rd!=0: value[rd] <= cmt_val[k]; multiple commits to same rd -> highest k wins.
//       busy[rd] cleared only if table tag == cmt_tag[k] (newer rename still pending stays busy).
//    2. Dispatch: dsp_en && dsp_rd!=0 && !flush -> busy[dsp_rd]<=1, tag[dsp_rd]<=dsp_tag; wins over step-1 clear on same reg.
//    3. Flush: all busy<=0, tags<=0; commits of the same cycle still write values; dispatch ignored.
//  - Writes to x0 (dispatch or commit) are discarded; value[0] is constant 0.
//  - rdy_in=0: no state change; inputs of that cycle are lost (upstream must hold).
//  - Same-cycle commit of tag T and dispatch of tag T to same reg (ROB wrap): dispatch wins, reg busy with T.
// STRUCTURE
//  - Shared constants.v: XLEN, RIDX_W, TAG_W defaults, REG_ZERO index.
//  - Sub-module regfile_cmt_merge: per-register reduction over NUM_CMT ports -> (hit, youngest val, tag_match);
//    reused by query forward path and write path. Storage: value/tag/busy arrays in top.
// TESTING
//  1. Reset then query x5,x6 -> val 0, busy 0, tag 0 on both ports.
//  2. Dispatch x5 tag 3; next cycle query x5 -> busy 1, tag 3; commit x5 tag 3 val 0xDEAD -> same cycle query busy 0, val 0xDEAD; next cycle table busy 0.
//  3. Dispatch x7 tag 2, then x7 tag 4; commit x7 tag 2 val 0x11 -> value 0x11, x7 stays busy tag 4.
//  4. NUM_CMT=2: commit x9 port0 val 1 and port1 val 2 same cycle -> value[x9]=2; dispatch x0 tag 5 -> x0 busy 0, val 0.
//  5. Busy x1..x4, flush with commit x2 val 7 and dispatch x3 tag 6 -> all busy 0, value[x2]=7, x3 not renamed.
//  6. rdy_in=0 with dispatch x8 tag 1 and commit x8 val 9 -> no state change; rst_in=1 with rdy_in=0 still clears all.

Source files
------------

// File: rtl/regfile_rename_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rename_mp_pkg
// Description : Shared constants for the multi-port register file / rename
//               table: default data, index and ROB-tag widths, and the index
//               of the hardwired zero register.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_rename_mp_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int RIDX_W_DEF = 5;
  localparam int TAG_W_DEF  = 4;

  // Index of the architectural zero register (never written, never busy).
  localparam logic [RIDX_W_DEF-1:0] REG_ZERO = '0;

endpackage : regfile_rename_mp_pkg
`default_nettype wire

// File: rtl/regfile_cmt_merge.sv
`default_nettype none
// ============================================================================
// Module      : regfile_cmt_merge
// Description : Reduces all commit ports against one register index.
//               Reports whether any enabled commit targets the register,
//               the value of the youngest such commit (highest port index)
//               and whether that youngest commit's tag equals the tag held
//               in the rename table for the register.
// Ports       : idx      in  RIDX_W          register being examined
//               tbl_tag  in  TAG_W           rename-table tag of idx
//               cmt_en   in  NUM_CMT         commit valid per port
//               cmt_rd   in  NUM_CMT*RIDX_W  commit destination per port
//               cmt_tag  in  NUM_CMT*TAG_W   commit ROB tag per port
//               cmt_val  in  NUM_CMT*XLEN    commit value per port
//               hit      out 1               some commit targets idx
//               val      out XLEN            youngest committed value
//               tag_match out 1              youngest commit tag == tbl_tag
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_cmt_merge #(
  parameter int XLEN    = 32,
  parameter int RIDX_W  = 5,
  parameter int TAG_W   = 4,
  parameter int NUM_CMT = 1
) (
  input  logic [RIDX_W-1:0]         idx,
  input  logic [TAG_W-1:0]          tbl_tag,
  input  logic [NUM_CMT-1:0]        cmt_en,
  input  logic [NUM_CMT*RIDX_W-1:0] cmt_rd,
  input  logic [NUM_CMT*TAG_W-1:0]  cmt_tag,
  input  logic [NUM_CMT*XLEN-1:0]   cmt_val,
  output logic                      hit,
  output logic [XLEN-1:0]           val,
  output logic                      tag_match
);

  // Ascending scan: a later (younger) matching port overwrites earlier ones.
  always_comb begin
    hit       = 1'b0;
    val       = '0;
    tag_match = 1'b0;
    for (int k = 0; k < NUM_CMT; k++) begin
      if (cmt_en[k] && (cmt_rd[k*RIDX_W +: RIDX_W] == idx)) begin
        hit       = 1'b1;
        val       = cmt_val[k*XLEN +: XLEN];
        tag_match = (cmt_tag[k*TAG_W +: TAG_W] == tbl_tag);
      end
    end
  end

endmodule : regfile_cmt_merge
`default_nettype wire

// File: rtl/regfile_rename_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rename_mp
// Description : Architectural register file with per-register rename state
//               (busy bit + producing ROB tag). NUM_RD combinational operand
//               query ports see this cycle's commits but not this cycle's
//               dispatch. NUM_CMT in-order commit ports, one dispatch port,
//               and a flush that drops all pending renames.
// Ports       : clk_in   in  1               clock
//               rst_in   in  1               synchronous active-high reset
//               rdy_in   in  1               global enable (low = hold state)
//               dsp_en   in  1               rename dsp_rd to dsp_tag
//               dsp_rd   in  RIDX_W          dispatched destination
//               dsp_tag  in  TAG_W           allocated ROB tag
//               q_rs     in  NUM_RD*RIDX_W   query indices
//               q_val    out NUM_RD*XLEN     operand values
//               q_busy   out NUM_RD          operand pending
//               q_tag    out NUM_RD*TAG_W    producing tag (0 when not busy)
//               cmt_en   in  NUM_CMT         commit valid
//               cmt_rd   in  NUM_CMT*RIDX_W  commit destination
//               cmt_tag  in  NUM_CMT*TAG_W   retiring ROB tag
//               cmt_val  in  NUM_CMT*XLEN    committed result
//               flush    in  1               mispredict rollback
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rename_mp
  import regfile_rename_mp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int RIDX_W  = RIDX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int NUM_CMT = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dsp_en,
  input  logic [RIDX_W-1:0]         dsp_rd,
  input  logic [TAG_W-1:0]          dsp_tag,
  input  logic [NUM_RD*RIDX_W-1:0]  q_rs,
  output logic [NUM_RD*XLEN-1:0]    q_val,
  output logic [NUM_RD-1:0]         q_busy,
  output logic [NUM_RD*TAG_W-1:0]   q_tag,
  input  logic [NUM_CMT-1:0]        cmt_en,
  input  logic [NUM_CMT*RIDX_W-1:0] cmt_rd,
  input  logic [NUM_CMT*TAG_W-1:0]  cmt_tag,
  input  logic [NUM_CMT*XLEN-1:0]   cmt_val,
  input  logic                      flush
);

  localparam logic [RIDX_W-1:0] ZERO_IDX = RIDX_W'(REG_ZERO);

  // Architectural state
  logic [XLEN-1:0]  value_q [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [NREG-1:0]  busy_q;

  // Per-register commit reduction for the write path
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] wr_match;
  logic [XLEN-1:0] wr_val [NREG];

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    regfile_cmt_merge #(
      .XLEN    (XLEN),
      .RIDX_W  (RIDX_W),
      .TAG_W   (TAG_W),
      .NUM_CMT (NUM_CMT)
    ) u_merge (
      .idx       (RIDX_W'(r)),
      .tbl_tag   (tag_q[r]),
      .cmt_en    (cmt_en),
      .cmt_rd    (cmt_rd),
      .cmt_tag   (cmt_tag),
      .cmt_val   (cmt_val),
      .hit       (wr_hit[r]),
      .val       (wr_val[r]),
      .tag_match (wr_match[r])
    );
  end : g_reg

  // Query ports: forward this cycle's commits, ignore this cycle's dispatch.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [RIDX_W-1:0] rs;
    logic              q_hit;
    logic              q_match;
    logic [XLEN-1:0]   q_fwd;
    logic              pend;

    assign rs = q_rs[i*RIDX_W +: RIDX_W];

    regfile_cmt_merge #(
      .XLEN    (XLEN),
      .RIDX_W  (RIDX_W),
      .TAG_W   (TAG_W),
      .NUM_CMT (NUM_CMT)
    ) u_merge (
      .idx       (rs),
      .tbl_tag   (tag_q[rs]),
      .cmt_en    (cmt_en),
      .cmt_rd    (cmt_rd),
      .cmt_tag   (cmt_tag),
      .cmt_val   (cmt_val),
      .hit       (q_hit),
      .val       (q_fwd),
      .tag_match (q_match)
    );

    always_comb begin
      pend = 1'b0;
      q_val[i*XLEN +: XLEN]    = '0;
      q_busy[i]                = 1'b0;
      q_tag[i*TAG_W +: TAG_W]  = '0;
      if (rs != ZERO_IDX) begin
        q_val[i*XLEN +: XLEN] = q_hit ? q_fwd : value_q[rs];
        // A commit of the tag the table is waiting on resolves the operand now.
        pend = busy_q[rs] && !(q_hit && q_match) && !flush;
        q_busy[i] = pend;
        q_tag[i*TAG_W +: TAG_W] = pend ? tag_q[rs] : '0;
      end
    end
  end : g_rd

  // State update. Statement order inside the enabled branch sets priority:
  // commit clear, then dispatch set, then flush clear-all.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
    end else if (rdy_in) begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          value_q[r] <= wr_val[r];
          if (wr_match[r]) begin
            busy_q[r] <= 1'b0;
          end
        end
      end
      if (dsp_en && (dsp_rd != ZERO_IDX) && !flush) begin
        busy_q[dsp_rd] <= 1'b1;
        tag_q[dsp_rd]  <= dsp_tag;
      end
      if (flush) begin
        busy_q <= '0;
        for (int r = 0; r < NREG; r++) begin
          tag_q[r] <= '0;
        end
      end
    end
  end

  // Entry 0 is never written outside reset; its merge outputs are don't-care.
  logic unused_zero;
  assign unused_zero = wr_hit[0] ^ wr_match[0] ^ (^wr_val[0]);

endmodule : regfile_rename_mp
`default_nettype wire

// File: tb/tb_regfile_rename_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_rename_mp
// Description : Directed self-checking bench for regfile_rename_mp with two
//               query ports and two commit ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_rename_mp;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 4;
  localparam int NRD  = 2;
  localparam int NCM  = 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              dsp_en;
  logic [RW-1:0]     dsp_rd;
  logic [TW-1:0]     dsp_tag;
  logic [NRD*RW-1:0] q_rs;
  logic [NRD*XLEN-1:0] q_val;
  logic [NRD-1:0]    q_busy;
  logic [NRD*TW-1:0] q_tag;
  logic [NCM-1:0]    cmt_en;
  logic [NCM*RW-1:0] cmt_rd;
  logic [NCM*TW-1:0] cmt_tag;
  logic [NCM*XLEN-1:0] cmt_val;
  logic              flush;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  regfile_rename_mp #(
    .XLEN(XLEN), .NREG(32), .RIDX_W(RW), .TAG_W(TW), .NUM_RD(NRD), .NUM_CMT(NCM)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .dsp_en  (dsp_en),
    .dsp_rd  (dsp_rd),
    .dsp_tag (dsp_tag),
    .q_rs    (q_rs),
    .q_val   (q_val),
    .q_busy  (q_busy),
    .q_tag   (q_tag),
    .cmt_en  (cmt_en),
    .cmt_rd  (cmt_rd),
    .cmt_tag (cmt_tag),
    .cmt_val (cmt_val),
    .flush   (flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic query(input int rs0, input int rs1);
    q_rs = {RW'(rs1), RW'(rs0)};
    #1;
  endtask

  task automatic set_cmt(input int k, input int rd, input int tg, input logic [31:0] v);
    cmt_en[k]            = 1'b1;
    cmt_rd[k*RW +: RW]   = RW'(rd);
    cmt_tag[k*TW +: TW]  = TW'(tg);
    cmt_val[k*XLEN +: XLEN] = v;
  endtask

  task automatic dispatch(input int rd, input int tg);
    dsp_en  = 1'b1;
    dsp_rd  = RW'(rd);
    dsp_tag = TW'(tg);
  endtask

  task automatic idle();
    dsp_en = 1'b0; dsp_rd = '0; dsp_tag = '0;
    cmt_en = '0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
    flush = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; q_rs = '0;
    idle();
    tick(); tick();
    rst_in = 1'b0;

    // 1: reset state
    query(5, 6);
    chk("rst_val0",  q_val[31:0], 32'h0);
    chk("rst_busy0", {31'b0, q_busy[0]}, 32'h0);
    chk("rst_tag0",  {28'b0, q_tag[3:0]}, 32'h0);
    chk("rst_val1",  q_val[63:32], 32'h0);
    chk("rst_busy1", {31'b0, q_busy[1]}, 32'h0);
    chk("rst_tag1",  {28'b0, q_tag[7:4]}, 32'h0);

    // 2: rename, then commit with forwarding
    dispatch(5, 3);
    query(5, 0);
    chk("own_rename_hidden", {31'b0, q_busy[0]}, 32'h0);
    tick(); idle();
    query(5, 0);
    chk("x5_busy", {31'b0, q_busy[0]}, 32'h1);
    chk("x5_tag",  {28'b0, q_tag[3:0]}, 32'h3);
    set_cmt(0, 5, 3, 32'hDEAD);
    #1;
    chk("x5_fwd_busy", {31'b0, q_busy[0]}, 32'h0);
    chk("x5_fwd_val",  q_val[31:0], 32'hDEAD);
    chk("x5_fwd_tag",  {28'b0, q_tag[3:0]}, 32'h0);
    tick(); idle(); #1;
    chk("x5_tbl_busy", {31'b0, q_busy[0]}, 32'h0);
    chk("x5_tbl_val",  q_val[31:0], 32'hDEAD);

    // 3: older commit does not clear a newer rename
    dispatch(7, 2); tick();
    dispatch(7, 4); tick(); idle();
    set_cmt(0, 7, 2, 32'h11);
    query(7, 0);
    chk("x7_fwd_val",  q_val[31:0], 32'h11);
    chk("x7_fwd_busy", {31'b0, q_busy[0]}, 32'h1);
    chk("x7_fwd_tag",  {28'b0, q_tag[3:0]}, 32'h4);
    tick(); idle(); #1;
    chk("x7_val",  q_val[31:0], 32'h11);
    chk("x7_busy", {31'b0, q_busy[0]}, 32'h1);
    chk("x7_tag",  {28'b0, q_tag[3:0]}, 32'h4);

    // 4: two commits to one register, youngest wins; dispatch to x0 discarded
    set_cmt(0, 9, 0, 32'h1);
    set_cmt(1, 9, 0, 32'h2);
    dispatch(0, 5);
    query(9, 0);
    chk("x9_fwd_val", q_val[31:0], 32'h2);
    tick(); idle();
    query(9, 0);
    chk("x9_val",  q_val[31:0], 32'h2);
    chk("x0_val",  q_val[63:32], 32'h0);
    chk("x0_busy", {31'b0, q_busy[1]}, 32'h0);
    chk("x0_tag",  {28'b0, q_tag[7:4]}, 32'h0);

    // 5: flush drops renames, keeps commit value, ignores dispatch
    for (int r = 1; r <= 4; r++) begin
      dispatch(r, 7 + r);
      tick();
    end
    idle();
    query(1, 4);
    chk("x1_busy_pre", {31'b0, q_busy[0]}, 32'h1);
    chk("x4_tag_pre",  {28'b0, q_tag[7:4]}, 32'hB);
    flush = 1'b1;
    set_cmt(0, 2, 9, 32'h7);
    dispatch(3, 6);
    query(1, 2);
    chk("flush_busy_x1", {31'b0, q_busy[0]}, 32'h0);
    chk("flush_tag_x1",  {28'b0, q_tag[3:0]}, 32'h0);
    chk("flush_fwd_x2",  q_val[63:32], 32'h7);
    tick(); idle();
    query(3, 2);
    chk("x3_busy",   {31'b0, q_busy[0]}, 32'h0);
    chk("x3_tag",    {28'b0, q_tag[3:0]}, 32'h0);
    chk("x2_val",    q_val[63:32], 32'h7);
    query(4, 7);
    chk("x4_busy",   {31'b0, q_busy[0]}, 32'h0);
    chk("x7_busy_f", {31'b0, q_busy[1]}, 32'h0);

    // 6: rdy_in low freezes state
    rdy_in = 1'b0;
    dispatch(8, 1);
    set_cmt(0, 8, 1, 32'h9);
    tick(); idle(); rdy_in = 1'b1;
    query(8, 0);
    chk("frz_val",  q_val[31:0], 32'h0);
    chk("frz_busy", {31'b0, q_busy[0]}, 32'h0);

    // ROB wrap: commit tag 5 and redispatch tag 5 on same register
    dispatch(10, 5); tick(); idle();
    dispatch(10, 5);
    set_cmt(1, 10, 5, 32'h55);
    tick(); idle();
    query(10, 0);
    chk("wrap_busy", {31'b0, q_busy[0]}, 32'h1);
    chk("wrap_tag",  {28'b0, q_tag[3:0]}, 32'h5);
    chk("wrap_val",  q_val[31:0], 32'h55);

    // Reset overrides rdy_in low
    rst_in = 1'b1; rdy_in = 1'b0;
    tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    query(10, 2);
    chk("rst2_busy", {31'b0, q_busy[0]}, 32'h0);
    chk("rst2_val10", q_val[31:0], 32'h0);
    chk("rst2_val2",  q_val[63:32], 32'h0);
    query(9, 5);
    chk("rst2_val9",  q_val[31:0], 32'h0);
    chk("rst2_val5",  q_val[63:32], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_rename_mp
`default_nettype wire
